// File: rtl/argmax_classifier.sv
// argmax_classifier
//   Final classification stage behind the dense output layer. It takes one
//   frame of NUM_CLASSES signed scores, one score per accepted beat, and
//   reports the index and value of the largest score. The result is held
//   until downstream accepts it. On a tie the lowest index wins.
//
// Ports
//   clk      rising-edge clock
//   rst_n    asynchronous active-low reset
//   s_valid  input score valid
//   s_ready  stage can accept a score (registered)
//   s_data   signed score, DATA_W bits
//   s_last   upstream end-of-frame marker; only checked, never used for framing
//   m_valid  classification result valid (registered)
//   m_ready  downstream accepts the result
//   m_class  index of the maximum score
//   m_score  value of the maximum score
//   err_len  sticky framing error, cleared only by rst_n
//   busy     high while scanning a frame or holding a result
module argmax_classifier #(
  parameter int NUM_CLASSES = 10,
  parameter int DATA_W      = 16,
  parameter int IDX_W       = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     s_valid,
  output logic                     s_ready,
  input  logic signed [DATA_W-1:0] s_data,
  input  logic                     s_last,
  output logic                     m_valid,
  input  logic                     m_ready,
  output logic        [IDX_W-1:0]  m_class,
  output logic        [DATA_W-1:0] m_score,
  output logic                     err_len,
  output logic                     busy
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SCAN = 2'd1,
    HOLD = 2'd2
  } state_t;

  // Count value carried into the final beat of a frame.
  localparam logic [IDX_W:0] LAST_CNT = (IDX_W + 1)'(NUM_CLASSES - 1);
  // A one-score frame finishes on the very first beat.
  localparam logic SINGLE = (NUM_CLASSES == 1);

  state_t                     state_r, state_n;
  logic        [IDX_W:0]      cnt_r, cnt_n;
  logic signed [DATA_W-1:0]   best_r, best_n;
  logic        [IDX_W-1:0]    idx_r, idx_n;
  logic        [IDX_W-1:0]    class_r, class_n;
  logic signed [DATA_W-1:0]   score_r, score_n;
  logic                       err_r, err_n;
  logic                       s_ready_r, s_ready_n;
  logic                       m_valid_r, m_valid_n;
  logic                       busy_r, busy_n;
  logic                       accept_s;
  logic                       final_s;

  assign accept_s = s_valid && s_ready_r;

  // Flag whether a beat accepted in the current state closes the frame.
  always_comb begin
    final_s = 1'b0;
    case (state_r)
      IDLE:    final_s = SINGLE;
      SCAN:    final_s = (cnt_r == LAST_CNT);
      default: final_s = 1'b0;
    endcase
  end

  // Next-state and datapath update.
  always_comb begin
    state_n = state_r;
    cnt_n   = cnt_r;
    best_n  = best_r;
    idx_n   = idx_r;
    class_n = class_r;
    score_n = score_r;
    err_n   = err_r;
    case (state_r)
      IDLE: begin
        if (accept_s) begin
          best_n = s_data;
          idx_n  = {IDX_W{1'b0}};
          cnt_n  = (IDX_W + 1)'(1);
          if (SINGLE) begin
            state_n = HOLD;
          end else begin
            state_n = SCAN;
          end
        end else begin
          state_n = IDLE;
        end
      end
      SCAN: begin
        if (accept_s) begin
          cnt_n = cnt_r + (IDX_W + 1)'(1);
          // Strictly greater: an equal later score never displaces an earlier one.
          if ($signed(s_data) > $signed(best_r)) begin
            best_n = s_data;
            idx_n  = cnt_r[IDX_W-1:0];
          end else begin
            best_n = best_r;
            idx_n  = idx_r;
          end
          if (final_s) begin
            state_n = HOLD;
          end else begin
            state_n = SCAN;
          end
        end else begin
          state_n = SCAN;
        end
      end
      HOLD: begin
        if (m_valid_r && m_ready) begin
          state_n = IDLE;
        end else begin
          state_n = HOLD;
        end
      end
      default: begin
        state_n = IDLE;
      end
    endcase

    // Snapshot the result into the output registers only when a frame closes,
    // so m_class/m_score stay put while the next frame is being scanned.
    if ((state_n == HOLD) && (state_r != HOLD)) begin
      class_n = idx_n;
      score_n = best_n;
    end else begin
      class_n = class_r;
      score_n = score_r;
    end

    // s_last must agree with the beat count; the frame still closes on count.
    if (accept_s && (s_last != final_s)) begin
      err_n = 1'b1;
    end else begin
      err_n = err_r;
    end
  end

  // Output decode from the next state so the handshake outputs are registered.
  always_comb begin
    s_ready_n = 1'b0;
    m_valid_n = 1'b0;
    busy_n    = 1'b0;
    case (state_n)
      IDLE: begin
        s_ready_n = 1'b1;
        m_valid_n = 1'b0;
        busy_n    = 1'b0;
      end
      SCAN: begin
        s_ready_n = 1'b1;
        m_valid_n = 1'b0;
        busy_n    = 1'b1;
      end
      HOLD: begin
        s_ready_n = 1'b0;
        m_valid_n = 1'b1;
        busy_n    = 1'b1;
      end
      default: begin
        s_ready_n = 1'b0;
        m_valid_n = 1'b0;
        busy_n    = 1'b0;
      end
    endcase
  end

  // State, datapath and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r   <= IDLE;
      cnt_r     <= {(IDX_W + 1){1'b0}};
      best_r    <= {DATA_W{1'b0}};
      idx_r     <= {IDX_W{1'b0}};
      class_r   <= {IDX_W{1'b0}};
      score_r   <= {DATA_W{1'b0}};
      err_r     <= 1'b0;
      s_ready_r <= 1'b0;
      m_valid_r <= 1'b0;
      busy_r    <= 1'b0;
    end else begin
      state_r   <= state_n;
      cnt_r     <= cnt_n;
      best_r    <= best_n;
      idx_r     <= idx_n;
      class_r   <= class_n;
      score_r   <= score_n;
      err_r     <= err_n;
      s_ready_r <= s_ready_n;
      m_valid_r <= m_valid_n;
      busy_r    <= busy_n;
    end
  end

  assign s_ready = s_ready_r;
  assign m_valid = m_valid_r;
  assign m_class = class_r;
  assign m_score = score_r;
  assign err_len = err_r;
  assign busy    = busy_r;

endmodule
